// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM stage (A) and a debug port (B)
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_stall,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int WAIT_W = MAX_WAIT > 1 ? $clog2(MAX_WAIT) : 1;
    typedef enum logic [1:0] {A_OWN, B_GRANT, B_ACK} state_t;
    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                sel_b;

    // State register; reset drops any in-flight B access
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= A_OWN;
            wait_cnt_q  <= '0;
            b_rdata_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            b_rdata_q   <= b_rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next state: B wins when A is idle or after MAX_WAIT denied cycles; grant is always followed by ack
    always_comb begin
        state_d     = state_q == B_GRANT ? B_ACK :
                      state_q == A_OWN && b_req && (!a_req || wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) ? B_GRANT : A_OWN;
        wait_cnt_d  = state_q == A_OWN && state_d == A_OWN && b_req && a_req ? wait_cnt_q + 1'b1 : '0;
        b_rdata_d   = sel_b ? (b_we ? b_wdata : m_rdata) : b_rdata_q;
        stall_cnt_d = a_stall && stall_cnt_q != '1 ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    // Outputs: memory mux follows B only in the grant cycle; memory is quiet while reset is held
    always_comb begin
        sel_b     = state_q == B_GRANT;
        a_stall   = sel_b && a_req;
        m_en      = !reset && (sel_b || a_req);
        m_we      = !reset && (sel_b ? b_we : a_req && a_we);
        m_addr    = sel_b ? b_addr : a_addr;
        m_wdata   = sel_b ? b_wdata : a_wdata;
        a_rdata   = m_rdata;
        b_ack     = state_q == B_ACK;
        b_rdata   = b_rdata_q;
        stall_cnt = stall_cnt_q;
    end
endmodule
